// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the data-side cache responder.
//   state_e           - responder FSM states
//   DCACHE_WORD_BYTES - bytes per cache line (one 32-bit word)
//   byte_merge        - per-byte merge of new data into an old word
package dcache_pkg;

  localparam int unsigned DCACHE_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_DONE,
    WR_REQ
  } state_e;

  function automatic logic [31:0] byte_merge(
    input logic [31:0]                  old_w,
    input logic [31:0]                  new_w,
    input logic [DCACHE_WORD_BYTES-1:0] mask
  );
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < DCACHE_WORD_BYTES; i++) begin
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for the direct-mapped data cache.
//   clk, rst         - clock, synchronous active-low reset (clears valid bits)
//   rd_idx_i         - combinational read port index
//   rd_valid/tag/data_o - line contents at rd_idx_i
//   wr_en_i, wr_idx_i, wr_tag_i, wr_data_i, wr_mask_i
//                    - write port; sets valid, writes tag, byte-merges data
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INDEX_BITS-1:0]        rd_idx_i,
  output logic                         rd_valid_o,
  output logic [TAG_BITS-1:0]          rd_tag_o,
  output logic [31:0]                  rd_data_o,
  input  logic                         wr_en_i,
  input  logic [INDEX_BITS-1:0]        wr_idx_i,
  input  logic [TAG_BITS-1:0]          wr_tag_i,
  input  logic [31:0]                  wr_data_i,
  input  logic [DCACHE_WORD_BYTES-1:0] wr_mask_i
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [DEPTH];
  logic [31:0]         data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= byte_merge(data_q[wr_idx_i], wr_data_i, wr_mask_i);
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache
// (one word per line) answering the core's dcache_* port and fronting a
// multi-cycle backing memory.
//   clk, rst (sync, active-low)
//   dcache_addr/re/we/din -> dcache_dout, stall      : core side
//   mem_req_valid/ready/rnw/addr/data/mask           : backing request channel
//   mem_resp_valid/data                              : backing read response
// Optional: define DCACHE_PERF_EN to add hit_count / miss_count outputs.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rnw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  state_e state_q, state_d;

  logic        req_valid_q;
  logic [29:0] req_addr_q;
  logic [3:0]  req_we_q;
  logic [31:0] req_din_q;
  logic [31:0] dout_q, dout_d;
  logic        stale_q;

  logic                  accept;
  logic                  is_wr;
  logic                  hit;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_data;
  logic                  arr_we;
  logic [31:0]           arr_wdata;
  logic [3:0]            arr_mask;
  logic                  addr_lsb_unused;

  assign addr_lsb_unused = ^dcache_addr[1:0];

  assign idx   = req_addr_q[INDEX_BITS-1:0];
  assign tag   = req_addr_q[29:INDEX_BITS];
  assign is_wr = |req_we_q;
  assign hit   = line_valid && (line_tag == tag);

  assign accept = !stall && (dcache_re || (|dcache_we));

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (arr_we),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (arr_wdata),
    .wr_mask_i  (arr_mask)
  );

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    dout_d    = dout_q;
    arr_we    = 1'b0;
    arr_mask  = '1;
    arr_wdata = mem_resp_data;
    case (state_q)
      IDLE: begin
        if (req_valid_q) begin
          if (is_wr) begin
            stall   = 1'b1;
            state_d = WR_REQ;
          end else if (hit) begin
            dout_d = line_data;
          end else begin
            stall   = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid && !stale_q) begin
          arr_we  = 1'b1;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        dout_d  = line_data;
        state_d = IDLE;
      end
      WR_REQ: begin
        stall     = 1'b1;
        arr_wdata = req_din_q;
        arr_mask  = req_we_q;
        if (mem_req_ready) begin
          arr_we  = hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= '0;
      req_din_q   <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      req_valid_q <= accept;
      if (accept) begin
        req_addr_q <= dcache_addr[31:2];
        req_we_q   <= dcache_we;
        req_din_q  <= dcache_din;
      end
    end
  end

  // A read in flight at reset still gets answered by memory; remember to
  // swallow that one response so a later miss cannot take it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stale_q <= (state_q == RD_WAIT) || (stale_q && !mem_resp_valid);
    end else if (mem_resp_valid) begin
      stale_q <= 1'b0;
    end
  end

  assign dcache_dout   = dout_d;
  assign mem_req_valid = rst && ((state_q == RD_REQ) || (state_q == WR_REQ));
  assign mem_req_rnw   = (state_q == RD_REQ);
  assign mem_req_addr  = req_addr_q;
  assign mem_req_data  = req_din_q;
  assign mem_req_mask  = (state_q == WR_REQ) ? req_we_q : '0;

`ifdef DCACHE_PERF_EN
  logic        rd_lookup;
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  assign rd_lookup = (state_q == IDLE) && req_valid_q && !is_wr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (rd_lookup && hit)  hit_q  <= hit_q + 32'd1;
      if (rd_lookup && !hit) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule
